// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the ProtoCore sequencer: ALU opcodes, instruction
// opcodes, instruction field positions, FSM state encoding and the bundle of
// datapath control signals produced by the decoder.
// Optional build macro: DATAPATH_CTRL_SINGLE_STEP_EN adds the PAUSE state.
package datapath_ctrl_pkg;

    // ALU operation encoding, identical to the datapath's own encoding
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_t;

    // Instruction opcodes (0x0..0x7 are ALU ops, 0xD/0xE are undefined)
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_BC   = 4'hB;
    localparam logic [3:0] OP_NOP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Instruction field positions
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RSA_MSB = 7;
    localparam int RSA_LSB = 4;
    localparam int RSB_MSB = 3;
    localparam int RSB_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Sequencer states; three bits so PAUSE fits when single-step is built in
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3
`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
        ,
        ST_PAUSE  = 3'd4
`endif
    } state_t;

    // Datapath control bundle driven during EXEC
    typedef struct packed {
        logic [2:0] alu_opcode;
        logic       alu_en;
        logic [3:0] ra_addr;
        logic [3:0] rb_addr;
        logic [3:0] write_addr;
        logic [7:0] imm_value;
        logic       write_en;
    } dp_ctrl_t;

    // Opcode field of an instruction word
    function automatic logic [3:0] instr_op(input logic [15:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    // True for the eight ALU opcodes
    function automatic logic instr_is_alu(input logic [15:0] instr);
        return ~instr[OP_MSB];
    endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Bus between the sequencer and the rest of ProtoCore: instruction memory
// address/data plus the datapath control and flag signals.
// master = sequencer side, slave = memory/datapath side.
interface datapath_ctrl_if #(
    parameter int PC_WIDTH = 8
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_data;
    logic [2:0]          alu_opcode;
    logic                alu_en;
    logic [3:0]          ra_addr;
    logic [3:0]          rb_addr;
    logic [3:0]          write_addr;
    logic [7:0]          imm_value;
    logic                write_en;
    logic                alu_zero;
    logic                alu_carry;

    modport master (
        output imem_addr,
        input  imem_data,
        output alu_opcode,
        output alu_en,
        output ra_addr,
        output rb_addr,
        output write_addr,
        output imm_value,
        output write_en,
        input  alu_zero,
        input  alu_carry
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  alu_opcode,
        input  alu_en,
        input  ra_addr,
        input  rb_addr,
        input  write_addr,
        input  imm_value,
        input  write_en,
        output alu_zero,
        output alu_carry
    );
endinterface

// File: rtl/datapath_ctrl_decode.sv
// Combinational instruction decoder: maps (state, ir, latched Z/C) to the
// datapath controls plus branch/halt/illegal qualifiers. Every output is
// inactive outside EXEC so the datapath never sees a stray write.
module datapath_ctrl_decode
    import datapath_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [15:0] ir,
    input  logic        flag_z,
    input  logic        flag_c,
    output dp_ctrl_t    ctrl,
    output logic        branch_taken,
    output logic        is_alu,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs_a;
    logic [3:0] rs_b;
    logic [7:0] imm8;

    assign op   = instr_op(ir);
    assign rd   = ir[RD_MSB:RD_LSB];
    assign rs_a = ir[RSA_MSB:RSA_LSB];
    assign rs_b = ir[RSB_MSB:RSB_LSB];
    assign imm8 = ir[IMM_MSB:IMM_LSB];

    // Decode the held instruction into datapath controls while in EXEC
    always_comb begin
        ctrl         = '0;
        branch_taken = 1'b0;
        is_alu       = 1'b0;
        is_halt      = 1'b0;
        is_illegal   = 1'b0;
        if (state == ST_EXEC) begin
            if (instr_is_alu(ir)) begin
                // NOT/shifts ignore rs_b inside the datapath; it is still driven
                is_alu          = 1'b1;
                ctrl.alu_opcode = op[2:0];
                ctrl.alu_en     = 1'b1;
                ctrl.ra_addr    = rs_a;
                ctrl.rb_addr    = rs_b;
                ctrl.write_addr = rd;
                ctrl.write_en   = 1'b1;
            end else begin
                case (op)
                    OP_LDI: begin
                        ctrl.write_addr = rd;
                        ctrl.imm_value  = imm8;
                        ctrl.write_en   = 1'b1;
                    end
                    OP_JMP:  branch_taken = 1'b1;
                    OP_BZ:   branch_taken = flag_z;
                    OP_BC:   branch_taken = flag_c;
                    OP_NOP:  ;
                    OP_HALT: is_halt = 1'b1;
                    default: is_illegal = 1'b1;
                endcase
            end
        end
    end

endmodule

// File: rtl/datapath_ctrl.sv
// ProtoCore sequencer. Fetches 16-bit instructions from a synchronous ROM,
// holds them in ir and drives the datapath through datapath_ctrl_if.
// Every instruction takes FETCH/DECODE/EXEC (three cycles).
// Optional build macro: DATAPATH_CTRL_SINGLE_STEP_EN adds the step input and
// a PAUSE state after each non-terminating EXEC.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; pc/flags/illegal reloaded on start
//   FETCH  | imem_addr = pc, ROM read in flight
//   DECODE | ir <- imem_data, pc <- pc + 1
//   EXEC   | datapath controls driven from ir; branch, flags, halt resolved
//   PAUSE  | (single-step builds only) wait for a step pulse
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
    input  logic step,
`endif
    output logic busy,
    output logic done,
    output logic illegal,
    datapath_ctrl_if.master bus
);

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [15:0]         ir;
    logic                flag_z;
    logic                flag_c;
    logic                start_armed;

    dp_ctrl_t            ctrl;
    logic                branch_taken;
    logic                is_alu;
    logic                is_halt;
    logic                is_illegal;

    datapath_ctrl_decode u_decode (
        .state        (state),
        .ir           (ir),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .ctrl         (ctrl),
        .branch_taken (branch_taken),
        .is_alu       (is_alu),
        .is_halt      (is_halt),
        .is_illegal   (is_illegal)
    );

    assign bus.imem_addr  = pc;
    assign bus.alu_opcode = ctrl.alu_opcode;
    assign bus.alu_en     = ctrl.alu_en;
    assign bus.ra_addr    = ctrl.ra_addr;
    assign bus.rb_addr    = ctrl.rb_addr;
    assign bus.write_addr = ctrl.write_addr;
    assign bus.imm_value  = ctrl.imm_value;
    assign bus.write_en   = ctrl.write_en;

    // Blocks a start that arrives on the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_armed <= 1'b0;
        end else begin
            start_armed <= 1'b1;
        end
    end

    // Sequencer FSM with pc, ir, flags and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            ir      <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && start_armed) begin
                        state   <= ST_FETCH;
                        pc      <= RESET_PC;
                        flag_z  <= 1'b0;
                        flag_c  <= 1'b0;
                        illegal <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir    <= bus.imem_data;
                    pc    <= pc + PC_WIDTH'(1);
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_alu) begin
                        flag_z <= bus.alu_zero;
                        flag_c <= bus.alu_carry;
                    end
                    if (branch_taken) begin
                        pc <= PC_WIDTH'(ir[IMM_MSB:IMM_LSB]);
                    end
                    if (is_halt || is_illegal) begin
                        // Terminating instructions never stop in PAUSE
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (is_illegal) begin
                            illegal <= 1'b1;
                        end
                    end else begin
`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
                        state <= ST_PAUSE;
`else
                        state <= ST_FETCH;
`endif
                    end
                end
`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
                ST_PAUSE: begin
                    if (step) begin
                        state <= ST_FETCH;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: synchronous ROM, 16x8 register file and ALU model
// around the DUT; an ISA-level interpreter predicts writes, final registers,
// final pc, illegal flag and run length for directed and random programs.
module tb_datapath_ctrl;
    import datapath_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
    logic step = 1'b1;
`endif
    logic busy;
    logic done;
    logic illegal;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    datapath_ctrl_if #(.PC_WIDTH(8)) bus ();

    datapath_ctrl #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
        .step    (step),
`endif
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .bus     (bus)
    );

    // ---------------- environment: ROM, register file, ALU ----------------
    logic [15:0] rom [256];
    logic [7:0]  rf [16];
    logic        rf_clr = 1'b0;
    logic [11:0] wlog [$];
    logic [8:0]  alu_res;
    logic [7:0]  wr_data;

    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {a < b, 8'(a - b)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {a[7], a[6:0], 1'b0};
            default: return {a[0], 1'b0, a[7:1]};
        endcase
    endfunction

    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    assign alu_res       = alu_f(bus.alu_opcode, rf[bus.ra_addr], rf[bus.rb_addr]);
    assign bus.alu_zero  = (alu_res[7:0] == 8'h00);
    assign bus.alu_carry = alu_res[8];
    assign wr_data       = bus.alu_en ? alu_res[7:0] : bus.imm_value;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
            wlog.delete();
        end else if (rst && bus.write_en) begin
            if (bus.write_addr != 4'd0) rf[bus.write_addr] <= wr_data;
            wlog.push_back({bus.write_addr, wr_data});
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- ISA-level reference ----------------
    logic [11:0] exp_w [$];
    logic [7:0]  ref_rf [16];

    function automatic int exp_cyc(input int n);
`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
        return 4 * n - 1;
`else
        return 3 * n;
`endif
    endfunction

    task automatic ref_run(output int n, output logic [7:0] fpc, output logic ill);
        logic [7:0]  pc;
        logic        z, c, stop;
        logic [15:0] ins;
        logic [3:0]  op, rd, ra, rb;
        logic [8:0]  r9;
        pc = 8'h00; z = 1'b0; c = 1'b0; stop = 1'b0; ill = 1'b0; n = 0;
        exp_w.delete();
        for (int i = 0; i < 16; i++) ref_rf[i] = 8'h00;
        while (!stop && n < 300) begin
            ins = rom[pc];
            pc  = pc + 8'd1;
            n++;
            op = ins[15:12]; rd = ins[11:8]; ra = ins[7:4]; rb = ins[3:0];
            if (op < 4'd8) begin
                r9 = alu_f(op[2:0], ref_rf[ra], ref_rf[rb]);
                exp_w.push_back({rd, r9[7:0]});
                if (rd != 4'd0) ref_rf[rd] = r9[7:0];
                z = (r9[7:0] == 8'h00);
                c = r9[8];
            end else begin
                case (op)
                    4'h8: begin
                        exp_w.push_back({rd, ins[7:0]});
                        if (rd != 4'd0) ref_rf[rd] = ins[7:0];
                    end
                    4'h9: pc = ins[7:0];
                    4'hA: if (z) pc = ins[7:0];
                    4'hB: if (c) pc = ins[7:0];
                    4'hC: ;
                    4'hF: stop = 1'b1;
                    default: begin stop = 1'b1; ill = 1'b1; end
                endcase
            end
        end
        fpc = pc;
    endtask

    // Run the program in rom from start to done and compare against the reference
    task automatic run_prog(input string tag, output int cyc);
        int         n;
        logic [7:0] fpc;
        logic       ill, prev_busy, got_done;
        ref_run(n, fpc, ill);
        @(negedge clk); rf_clr = 1'b1;
        @(negedge clk); rf_clr = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        prev_busy = busy;
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got_done = 1'b1;
            else prev_busy = busy;
        end
        chk({tag, "_done_seen"}, got_done, 1'b1);
        if (!got_done) return;
        chk({tag, "_cycles"}, cyc, exp_cyc(n));
        chk({tag, "_busy_before_done"}, prev_busy, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_final_pc"}, bus.imem_addr, fpc);
        chk({tag, "_illegal"}, illegal, ill);
        chk({tag, "_nwrites"}, wlog.size(), exp_w.size());
        for (int i = 0; i < wlog.size() && i < exp_w.size(); i++)
            chk($sformatf("%s_write%0d", tag, i), wlog[i], exp_w[i]);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_r%0d", tag, i), rf[i], ref_rf[i]);
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    task automatic load_rom(input logic [15:0] prog [$]);
        for (int a = 0; a < 256; a++) rom[a] = 16'hF000;
        foreach (prog[i]) rom[i] = prog[i];
    endtask

    task automatic gen_prog();
        int len, k;
        logic [15:0] w;
        len = $urandom_range(12, 3);
        for (int a = 0; a < 256; a++) rom[a] = 16'hF000;
        for (int i = 0; i < len; i++) begin
            k = $urandom_range(99, 0);
            w = 16'($urandom);
            if (k < 40)      w[15:12] = 4'($urandom_range(7, 0));
            else if (k < 70) w[15:12] = 4'h8;
            else if (k < 88) begin
                w[15:12] = 4'($urandom_range(11, 9));
                w[7:0]   = 8'($urandom_range(len, i + 1));
            end
            else if (k < 94) w[15:12] = 4'hC;
            else if (k < 97) w[15:12] = 4'($urandom_range(14, 13));
            else             w[15:12] = 4'hF;
            rom[i] = w;
        end
    endtask

    // Wait (bounded) until write_en is seen just after a rising edge
    task automatic wait_write(input string tag);
        int   t;
        logic seen;
        seen = 1'b0;
        t = 0;
        while (!seen && t < 200) begin
            @(posedge clk); #1;
            t++;
            if (bus.write_en) seen = 1'b1;
        end
        chk({tag, "_write_seen"}, seen, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, n3;
        load_rom('{16'hF000});
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_write_en", bus.write_en, 1'b0);
        chk("rst_alu_en", bus.alu_en, 1'b0);
        chk("rst_imem_addr", bus.imem_addr, 8'h00);
        chk("rst_write_addr", bus.write_addr, 4'h0);
        chk("rst_imm", bus.imm_value, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // LDI/LDI/ADD/HALT
        load_rom('{16'h8105, 16'h8203, 16'h0312, 16'hF000});
        run_prog("s1", cyc);
        chk("s1_r3_is_8", rf[3], 8'h08);
        chk("s1_cycles_12", cyc, exp_cyc(4));

        // carry + zero from ADD, BC taken to addr 5
        load_rom('{16'h81FF, 16'h8201, 16'h0312, 16'hB005, 16'hF000, 16'hF000});
        run_prog("s2", cyc);
        chk("s2_r3_zero", rf[3], 8'h00);
        chk("s2_halt_at_5", bus.imem_addr, 8'h06);

        // SUB gives zero, BZ skips the LDI r3
        load_rom('{16'h8101, 16'h1211, 16'hA004, 16'h8377, 16'hF000});
        run_prog("s3", cyc);
        n3 = 0;
        foreach (wlog[i]) if (wlog[i][11:8] == 4'd3) n3++;
        chk("s3_no_r3_write", n3, 0);

        // asynchronous reset in the middle of an LDI EXEC
        load_rom('{16'h8107, 16'h9000});
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_write("s4");
        rst = 1'b0;
        #1;
        chk("s4_rst_write_en", bus.write_en, 1'b0);
        chk("s4_rst_alu_en", bus.alu_en, 1'b0);
        chk("s4_rst_busy", busy, 1'b0);
        chk("s4_rst_done", done, 1'b0);
        chk("s4_rst_imem_addr", bus.imem_addr, 8'h00);
        chk("s4_rst_write_addr", bus.write_addr, 4'h0);
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("s4_start_at_release_ignored", busy, 1'b0);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("s4_restart_busy", busy, 1'b1);
        chk("s4_restart_pc0", bus.imem_addr, 8'h00);
        wait_write("s4b");
        chk("s4_restart_addr", bus.write_addr, 4'h1);
        chk("s4_restart_imm", bus.imm_value, 8'h07);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);

        // undefined opcode at address 0, then a fresh start clears illegal
        load_rom('{16'hD000});
        run_prog("s5", cyc);
        chk("s5_illegal_set", illegal, 1'b1);
        load_rom('{16'h8142, 16'hF000});
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("s5_illegal_cleared", illegal, 1'b0);
        repeat (10) @(negedge clk);
        chk("s5_second_run_idle", busy, 1'b0);

`ifdef DATAPATH_CTRL_SINGLE_STEP_EN
        // one instruction per step pulse
        step = 1'b0;
        load_rom('{16'h8105, 16'h8203, 16'h0312, 16'hF000});
        @(negedge clk); rf_clr = 1'b1;
        @(negedge clk); rf_clr = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        chk("ss_paused_busy", busy, 1'b1);
        chk("ss_writes_1", wlog.size(), 1);
        for (int s = 2; s <= 3; s++) begin
            step = 1'b1; @(negedge clk); step = 1'b0;
            repeat (8) @(negedge clk);
            chk($sformatf("ss_writes_%0d", s), wlog.size(), s);
            chk($sformatf("ss_busy_%0d", s), busy, 1'b1);
        end
        step = 1'b1; @(negedge clk); step = 1'b0;
        repeat (5) @(negedge clk);
        chk("ss_halted", busy, 1'b0);
        chk("ss_r3", rf[3], 8'h08);
        step = 1'b1;
`endif

        // random programs with forward-only control flow
        for (int p = 0; p < 25; p++) begin
            gen_prog();
            run_prog($sformatf("rnd%0d", p), cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
